// File: rtl/tone_sequencer_if.sv
// Control, table-write and status signals between the tone sequencer and its
// controller; the sequencer takes the slave side.
interface tone_sequencer_if #(
    parameter int DEPTH     = 16,
    parameter int HW_WIDTH  = 20,
    parameter int DUR_WIDTH = 16
);
    localparam int AW = $clog2(DEPTH);

    logic                          wr_en;
    logic [AW-1:0]                 wr_addr;
    logic [HW_WIDTH+DUR_WIDTH-1:0] wr_data;
    logic                          start;
    logic                          stop;
    logic                          loop;
    logic                          busy;
    logic                          gate;
    logic [HW_WIDTH-1:0]           half_period;
    logic [AW-1:0]                 note_index;
    logic                          done;

    modport master (
        output wr_en, wr_addr, wr_data, start, stop, loop,
        input  busy, gate, half_period, note_index, done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start, stop, loop,
        output busy, gate, half_period, note_index, done
    );
endinterface

// File: rtl/tone_sequencer.sv
// Steps through a note table and drives the square-wave oscillator's
// half-period and gate with tick-granularity note durations.
//
// state | meaning
// IDLE  | outputs quiet, waiting for start
// LOAD  | one cycle: read table[note_index], decide next note / loop / end
// PLAY  | current note sounding; tick and duration counters running
module tone_sequencer #(
    parameter int DEPTH     = 16,
    parameter int HW_WIDTH  = 20,
    parameter int DUR_WIDTH = 16,
    parameter int TICK_DIV  = 50_000
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    tone_sequencer_if.slave    bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = HW_WIDTH + DUR_WIDTH;
    localparam int TW = $clog2(TICK_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PLAY = 2'd2
    } state_t;

    state_t               state_q, state_n;
    logic [EW-1:0]        table_q [DEPTH];
    logic [AW-1:0]        idx_q, idx_n;
    logic [HW_WIDTH-1:0]  hp_q, hp_n;
    logic                 gate_q, gate_n;
    logic                 busy_q;
    logic                 done_q, done_n;
    logic [DUR_WIDTH-1:0] dur_q, dur_n;
    logic [TW-1:0]        tick_q, tick_n;

    logic [EW-1:0]        entry;
    logic [HW_WIDTH-1:0]  ent_hp;
    logic [DUR_WIDTH-1:0] ent_dur;

    // Registered write, combinational read: a LOAD coinciding with a write
    // to the same entry naturally sees the old contents.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                table_q[i] <= '0;
            end
        end else if (bus.wr_en) begin
            table_q[bus.wr_addr] <= bus.wr_data;
        end
    end

    assign entry   = table_q[idx_q];
    assign ent_hp  = entry[EW-1:DUR_WIDTH];
    assign ent_dur = entry[DUR_WIDTH-1:0];

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            hp_q    <= '0;
            gate_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dur_q   <= '0;
            tick_q  <= '0;
        end else begin
            state_q <= state_n;
            idx_q   <= idx_n;
            hp_q    <= hp_n;
            gate_q  <= gate_n;
            busy_q  <= (state_n != IDLE);
            done_q  <= done_n;
            dur_q   <= dur_n;
            tick_q  <= tick_n;
        end
    end

    always_comb begin
        state_n = state_q;
        idx_n   = idx_q;
        hp_n    = hp_q;
        gate_n  = gate_q;
        done_n  = 1'b0;
        dur_n   = dur_q;
        tick_n  = tick_q;

        if (bus.stop) begin
            state_n = IDLE;
            hp_n    = '0;
            gate_n  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    hp_n   = '0;
                    gate_n = 1'b0;
                    if (bus.start) begin
                        idx_n   = '0;
                        state_n = LOAD;
                    end
                end
                LOAD: begin
                    if (ent_dur == '0) begin
                        // A marker at entry 0 always ends, so an empty table cannot spin
                        if (bus.loop && (idx_q != '0)) begin
                            idx_n   = '0;
                            state_n = LOAD;
                        end else begin
                            done_n  = 1'b1;
                            hp_n    = '0;
                            gate_n  = 1'b0;
                            state_n = IDLE;
                        end
                    end else begin
                        hp_n    = ent_hp;
                        gate_n  = (ent_hp != '0);
                        dur_n   = ent_dur;
                        tick_n  = TICK_LAST;
                        state_n = PLAY;
                    end
                end
                PLAY: begin
                    if (tick_q == '0) begin
                        tick_n = TICK_LAST;
                        dur_n  = dur_q - 1'b1;
                        if (dur_q == DUR_WIDTH'(1)) begin
                            idx_n   = idx_q + 1'b1;
                            state_n = LOAD;
                        end
                    end else begin
                        tick_n = tick_q - 1'b1;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.gate        = gate_q;
    assign bus.half_period = hp_q;
    assign bus.note_index  = idx_q;
    assign bus.done        = done_q;
endmodule

// File: tb/tb_tone_sequencer.sv
// Scoreboard bench for tone_sequencer: expected note segments (pitch, gate,
// length in cycles) are queued at start and compared with observed segments.
module tb_tone_sequencer;
    localparam int DEPTH = 16;
    localparam int HW    = 20;
    localparam int DW    = 16;
    localparam int TD    = 4;

    logic CLOCK_50 = 1'b0;
    logic reset    = 1'b1;
    always #10 CLOCK_50 = ~CLOCK_50;

    tone_sequencer_if #(.DEPTH(DEPTH), .HW_WIDTH(HW), .DUR_WIDTH(DW)) seq_if ();

    tone_sequencer #(
        .DEPTH(DEPTH), .HW_WIDTH(HW), .DUR_WIDTH(DW), .TICK_DIV(TD)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .bus      (seq_if)
    );

    typedef struct packed {
        logic [HW-1:0] hp;
        logic          gate;
        logic [31:0]   len;
    } seg_t;

    seg_t exp_q[$];
    seg_t obs_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   done_cnt     = 0;
    int   gate_cnt     = 0;
    int   wrap_cnt     = 0;
    logic cur_valid    = 1'b0;
    seg_t cur;
    logic [HW:0] prev_key = '0;
    logic [3:0]  prev_idx = '0;

    // Segment monitor: a segment opens on an output change while busy and
    // closes on the next change or when busy falls.
    always @(negedge CLOCK_50) begin
        logic [HW:0] key;
        key = {seq_if.gate, seq_if.half_period};
        if (seq_if.done === 1'b1) done_cnt++;
        if (seq_if.gate === 1'b1) gate_cnt++;
        if (prev_idx == 4'd15 && seq_if.note_index == 4'd0) wrap_cnt++;
        prev_idx = seq_if.note_index;
        if (key !== prev_key) begin
            if (cur_valid) obs_q.push_back(cur);
            cur_valid = (seq_if.busy === 1'b1);
            cur.hp    = seq_if.half_period;
            cur.gate  = seq_if.gate;
            cur.len   = 32'd1;
        end else if (cur_valid) begin
            if (seq_if.busy !== 1'b1) begin
                obs_q.push_back(cur);
                cur_valid = 1'b0;
            end else begin
                cur.len = cur.len + 32'd1;
            end
        end
        prev_key = key;
    end

    function automatic seg_t mk_seg(input logic [HW-1:0] hp, input logic g, input int len);
        seg_t s;
        s.hp   = hp;
        s.gate = g;
        s.len  = 32'(len);
        return s;
    endfunction

    task automatic mon_clear();
        obs_q.delete();
        exp_q.delete();
        done_cnt  = 0;
        gate_cnt  = 0;
        wrap_cnt  = 0;
        cur_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge CLOCK_50);
        reset = 1'b1;
        seq_if.start = 1'b0;
        seq_if.stop  = 1'b0;
        seq_if.loop  = 1'b0;
        seq_if.wr_en = 1'b0;
        repeat (2) @(negedge CLOCK_50);
        reset = 1'b0;
        @(negedge CLOCK_50);
    endtask

    task automatic write_entry(input int addr, input logic [HW-1:0] hp, input logic [DW-1:0] dur);
        seq_if.wr_en   = 1'b1;
        seq_if.wr_addr = 4'(addr);
        seq_if.wr_data = {hp, dur};
        @(negedge CLOCK_50);
        seq_if.wr_en   = 1'b0;
    endtask

    task automatic load_basic();
        write_entry(0, 20'd56818, 16'd2);
        write_entry(1, 20'd0,     16'd1);
        write_entry(2, 20'd28409, 16'd3);
        write_entry(3, 20'd12345, 16'd0);
    endtask

    task automatic pulse_start();
        seq_if.start = 1'b1;
        @(negedge CLOCK_50);
        seq_if.start = 1'b0;
    endtask

    task automatic test_reset();
        seq_if.start = 1'b0;
        seq_if.stop  = 1'b0;
        seq_if.loop  = 1'b0;
        seq_if.wr_en = 1'b0;
        seq_if.wr_addr = '0;
        seq_if.wr_data = '0;
        reset = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        tests_run++; if (seq_if.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", seq_if.busy); end
        tests_run++; if (seq_if.gate !== 1'b0) begin tests_failed++; $display("FAIL reset_gate: got %b want 0", seq_if.gate); end
        tests_run++; if (seq_if.done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b want 0", seq_if.done); end
        tests_run++; if (seq_if.half_period !== 20'd0) begin tests_failed++; $display("FAIL reset_hp: got %0d want 0", seq_if.half_period); end
        tests_run++; if (seq_if.note_index !== 4'd0) begin tests_failed++; $display("FAIL reset_idx: got %0d want 0", seq_if.note_index); end
        reset = 1'b0;
        @(negedge CLOCK_50);
    endtask

    task automatic test_empty();
        do_reset();
        mon_clear();
        seq_if.loop = 1'b1;
        pulse_start();
        tests_run++; if (seq_if.busy !== 1'b1) begin tests_failed++; $display("FAIL empty_busy_t1: got %b want 1", seq_if.busy); end
        tests_run++; if (seq_if.done !== 1'b0) begin tests_failed++; $display("FAIL empty_done_t1: got %b want 0", seq_if.done); end
        @(negedge CLOCK_50);
        tests_run++; if (seq_if.done !== 1'b1) begin tests_failed++; $display("FAIL empty_done_t2: got %b want 1", seq_if.done); end
        tests_run++; if (seq_if.busy !== 1'b0) begin tests_failed++; $display("FAIL empty_busy_t2: got %b want 0", seq_if.busy); end
        @(negedge CLOCK_50);
        tests_run++; if (seq_if.done !== 1'b0) begin tests_failed++; $display("FAIL empty_done_t3: got %b want 0", seq_if.done); end
        repeat (6) @(negedge CLOCK_50);
        tests_run++; if (gate_cnt != 0) begin tests_failed++; $display("FAIL empty_gate: got %0d gate cycles want 0", gate_cnt); end
        tests_run++; if (done_cnt != 1) begin tests_failed++; $display("FAIL empty_done_count: got %0d want 1", done_cnt); end
        seq_if.loop = 1'b0;
    endtask

    task automatic test_basic();
        int b;
        do_reset();
        load_basic();
        mon_clear();
        exp_q.push_back(mk_seg(20'd56818, 1'b1, 2*TD+1));
        exp_q.push_back(mk_seg(20'd0,     1'b0, 1*TD+1));
        exp_q.push_back(mk_seg(20'd28409, 1'b1, 3*TD+1));
        pulse_start();
        for (b = 0; b < 200 && done_cnt == 0; b++) @(negedge CLOCK_50);
        tests_run++; if (b >= 200) begin tests_failed++; $display("FAIL basic_timeout: got no done within %0d cycles want done", b); end
        repeat (3) @(negedge CLOCK_50);
        tests_run++; if (done_cnt != 1) begin tests_failed++; $display("FAIL basic_done_count: got %0d want 1", done_cnt); end
        tests_run++; if (seq_if.busy !== 1'b0) begin tests_failed++; $display("FAIL basic_busy_end: got %b want 0", seq_if.busy); end
        tests_run++; if (seq_if.gate !== 1'b0) begin tests_failed++; $display("FAIL basic_gate_end: got %b want 0", seq_if.gate); end
        tests_run++; if (obs_q.size() != exp_q.size()) begin tests_failed++; $display("FAIL basic_seg_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
            seg_t e, o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL basic_seg%0d: got hp=%0d gate=%0d len=%0d want hp=%0d gate=%0d len=%0d",
                         i, o.hp, o.gate, o.len, e.hp, e.gate, e.len);
            end
        end
    endtask

    task automatic test_loop();
        int   b;
        logic saw2, dropped;
        do_reset();
        load_basic();
        mon_clear();
        exp_q.push_back(mk_seg(20'd56818, 1'b1, 2*TD+1));
        exp_q.push_back(mk_seg(20'd0,     1'b0, 1*TD+1));
        exp_q.push_back(mk_seg(20'd28409, 1'b1, 3*TD+2));
        exp_q.push_back(mk_seg(20'd56818, 1'b1, 2*TD+1));
        exp_q.push_back(mk_seg(20'd0,     1'b0, 1*TD+1));
        exp_q.push_back(mk_seg(20'd28409, 1'b1, 3*TD+1));
        seq_if.loop = 1'b1;
        saw2    = 1'b0;
        dropped = 1'b0;
        pulse_start();
        for (b = 0; b < 400 && done_cnt == 0; b++) begin
            @(negedge CLOCK_50);
            if (seq_if.note_index == 4'd2) saw2 = 1'b1;
            if (!dropped && saw2 && seq_if.note_index == 4'd0 && seq_if.half_period == 20'd56818) begin
                tests_run++;
                if (done_cnt != 0) begin tests_failed++; $display("FAIL loop_no_done: got %0d done pulses want 0", done_cnt); end
                seq_if.loop = 1'b0;
                dropped = 1'b1;
            end
        end
        tests_run++; if (!dropped || b >= 400) begin tests_failed++; $display("FAIL loop_timeout: got dropped=%b cycles=%0d want loop back then done", dropped, b); end
        repeat (3) @(negedge CLOCK_50);
        tests_run++; if (done_cnt != 1) begin tests_failed++; $display("FAIL loop_done_count: got %0d want 1", done_cnt); end
        tests_run++; if (obs_q.size() != exp_q.size()) begin tests_failed++; $display("FAIL loop_seg_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
            seg_t e, o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL loop_seg%0d: got hp=%0d gate=%0d len=%0d want hp=%0d gate=%0d len=%0d",
                         i, o.hp, o.gate, o.len, e.hp, e.gate, e.len);
            end
        end
    endtask

    task automatic test_stop();
        int b;
        do_reset();
        load_basic();
        mon_clear();
        exp_q.push_back(mk_seg(20'd56818, 1'b1, 5));
        pulse_start();
        for (b = 0; b < 10 && seq_if.half_period !== 20'd56818; b++) @(negedge CLOCK_50);
        tests_run++; if (b >= 10) begin tests_failed++; $display("FAIL stop_note_timeout: got hp=%0d want 56818", seq_if.half_period); end
        repeat (4) @(negedge CLOCK_50);
        seq_if.stop = 1'b1;
        @(negedge CLOCK_50);
        seq_if.stop = 1'b0;
        tests_run++; if (seq_if.busy !== 1'b0) begin tests_failed++; $display("FAIL stop_busy: got %b want 0", seq_if.busy); end
        tests_run++; if (seq_if.gate !== 1'b0) begin tests_failed++; $display("FAIL stop_gate: got %b want 0", seq_if.gate); end
        tests_run++; if (seq_if.half_period !== 20'd0) begin tests_failed++; $display("FAIL stop_hp: got %0d want 0", seq_if.half_period); end
        repeat (20) @(negedge CLOCK_50);
        tests_run++; if (done_cnt != 0) begin tests_failed++; $display("FAIL stop_done: got %0d pulses want 0", done_cnt); end
        tests_run++; if (obs_q.size() != 1) begin tests_failed++; $display("FAIL stop_seg_count: got %0d want 1", obs_q.size()); end
        if (obs_q.size() > 0) begin
            seg_t e, o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL stop_seg: got hp=%0d gate=%0d len=%0d want hp=%0d gate=%0d len=%0d",
                         o.hp, o.gate, o.len, e.hp, e.gate, e.len);
            end
        end
        seq_if.start = 1'b1;
        seq_if.stop  = 1'b1;
        @(negedge CLOCK_50);
        seq_if.start = 1'b0;
        seq_if.stop  = 1'b0;
        tests_run++; if (seq_if.busy !== 1'b0) begin tests_failed++; $display("FAIL startstop_busy1: got %b want 0", seq_if.busy); end
        @(negedge CLOCK_50);
        tests_run++; if (seq_if.busy !== 1'b0) begin tests_failed++; $display("FAIL startstop_busy2: got %b want 0", seq_if.busy); end
        tests_run++; if (seq_if.gate !== 1'b0) begin tests_failed++; $display("FAIL startstop_gate: got %b want 0", seq_if.gate); end
    endtask

    task automatic test_write_during_play();
        int b;
        do_reset();
        load_basic();
        mon_clear();
        exp_q.push_back(mk_seg(20'd56818, 1'b1, 2*TD+1));
        exp_q.push_back(mk_seg(20'd0,     1'b0, 1*TD+1));
        exp_q.push_back(mk_seg(20'd11364, 1'b1, 1*TD+1));
        pulse_start();
        for (b = 0; b < 10 && seq_if.half_period !== 20'd56818; b++) @(negedge CLOCK_50);
        write_entry(2, 20'd11364, 16'd1);
        for (b = 0; b < 20 && seq_if.note_index !== 4'd1; b++) @(negedge CLOCK_50);
        tests_run++; if (b >= 20) begin tests_failed++; $display("FAIL wr_load_timeout: got idx=%0d want 1", seq_if.note_index); end
        write_entry(1, 20'd777, 16'd3);
        for (b = 0; b < 100 && done_cnt == 0; b++) @(negedge CLOCK_50);
        repeat (3) @(negedge CLOCK_50);
        tests_run++; if (done_cnt != 1) begin tests_failed++; $display("FAIL wr_done_count: got %0d want 1", done_cnt); end
        tests_run++; if (obs_q.size() != exp_q.size()) begin tests_failed++; $display("FAIL wr_seg_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
            seg_t e, o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL wr_seg%0d: got hp=%0d gate=%0d len=%0d want hp=%0d gate=%0d len=%0d",
                         i, o.hp, o.gate, o.len, e.hp, e.gate, e.len);
            end
        end
    endtask

    task automatic test_full_table();
        int b;
        int busy_low;
        do_reset();
        for (int i = 0; i < DEPTH; i++) write_entry(i, 20'((i + 1) * 100), 16'd1);
        mon_clear();
        for (int i = 0; i < 20; i++) exp_q.push_back(mk_seg(20'(((i % DEPTH) + 1) * 100), 1'b1, TD + 1));
        busy_low = 0;
        pulse_start();
        for (b = 0; b < 300 && obs_q.size() < 20; b++) begin
            @(negedge CLOCK_50);
            if (seq_if.busy !== 1'b1) busy_low++;
        end
        tests_run++; if (b >= 300) begin tests_failed++; $display("FAIL full_timeout: got %0d segments want 20", obs_q.size()); end
        tests_run++; if (busy_low != 0) begin tests_failed++; $display("FAIL full_busy: got %0d low cycles want 0", busy_low); end
        tests_run++; if (done_cnt != 0) begin tests_failed++; $display("FAIL full_done: got %0d pulses want 0", done_cnt); end
        tests_run++; if (wrap_cnt < 1) begin tests_failed++; $display("FAIL full_wrap: got %0d wraps want >=1", wrap_cnt); end
        for (int i = 0; i < 20 && obs_q.size() > 0; i++) begin
            seg_t e, o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL full_seg%0d: got hp=%0d gate=%0d len=%0d want hp=%0d gate=%0d len=%0d",
                         i, o.hp, o.gate, o.len, e.hp, e.gate, e.len);
            end
        end
        seq_if.stop = 1'b1;
        @(negedge CLOCK_50);
        seq_if.stop = 1'b0;
    endtask

    initial begin
        test_reset();
        test_empty();
        test_basic();
        test_loop();
        test_stop();
        test_write_during_play();
        test_full_table();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish want finish before 2 ms");
        $fatal(1, "time limit");
    end
endmodule
